// File: rtl/ctrl_encode_def_pkg.sv
// Shared control encodings: data-memory access codes and responder FSM states.
// The DM_* macros and the package constants carry the same values.
`ifndef CTRL_ENCODE_DEF_SVH
`define CTRL_ENCODE_DEF_SVH
`define DM_WORD      3'b000
`define DM_HALF      3'b001
`define DM_HALF_U    3'b010
`define DM_BYTE      3'b011
`define DM_BYTE_U    3'b100
`endif

package ctrl_encode_def_pkg;

    localparam logic [2:0] DM_WORD   = `DM_WORD;
    localparam logic [2:0] DM_HALF   = `DM_HALF;
    localparam logic [2:0] DM_HALF_U = `DM_HALF_U;
    localparam logic [2:0] DM_BYTE   = `DM_BYTE;
    localparam logic [2:0] DM_BYTE_U = `DM_BYTE_U;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_align.sv
// Lane steering for data memory: byte enables, store replication,
// load lane extraction with sign/zero extension, alignment checks.
module dm_align
    import ctrl_encode_def_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = rword[{addr_lo, 3'b000} +: 8];
        h     = addr_lo[1] ? rword[31:16] : rword[15:0];
        be    = 4'h0;
        wdata = wdata_in;
        rdata = 32'h0;
        err   = 1'b0;
        unique case (dm_type)
            DM_WORD: begin
                be    = 4'hF;
                rdata = rword;
                err   = (addr_lo != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                be    = addr_lo[1] ? 4'hC : 4'h3;
                wdata = {2{wdata_in[15:0]}};
                rdata = (dm_type == DM_HALF) ? {{16{h[15]}}, h}
                                             : {16'h0, h};
                err   = addr_lo[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wdata_in[7:0]}};
                rdata = (dm_type == DM_BYTE) ? {{24{b[7]}}, b}
                                             : {24'h0, b};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory with a latched request, programmable wait states and a
// one-cycle completion pulse; RAM is an inferred byte-enabled array.
module data_mem_responder
    import ctrl_encode_def_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        acc_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dm_state_t   state, state_nxt;
    logic [3:0]  cnt;
    logic        req_w;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_type;
    logic [31:0] data_q;
    logic [31:0] ram [DEPTH_WORDS];

    logic          accept, done, err, range_err, align_err;
    logic [3:0]    be;
    logic [31:0]   wdata, rdata, rword, load_val;
    logic [AW-1:0] widx;

    assign accept    = (state == DM_IDLE) && CPU_MIO;
    assign done      = (state == DM_DONE);
    assign widx      = req_addr[AW+1:2];
    assign rword     = ram[widx];
    assign range_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign err       = range_err | align_err;
    assign load_val  = err ? 32'h0 : rdata;

    assign MIO_ready = done;
    assign acc_err   = done & err;
    assign Data_out  = (done && !req_w) ? load_val : data_q;

    dm_align u_align (
        .dm_type  (req_type),
        .addr_lo  (req_addr[1:0]),
        .wdata_in (req_data),
        .rword    (rword),
        .be       (be),
        .wdata    (wdata),
        .rdata    (rdata),
        .err      (align_err)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            DM_IDLE: if (CPU_MIO)
                state_nxt = (WAIT_CYCLES == 0) ? DM_DONE : DM_WAIT;
            DM_WAIT: if (cnt == 4'd1) state_nxt = DM_DONE;
            DM_DONE: state_nxt = DM_IDLE;
            default: state_nxt = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DM_IDLE;
            cnt      <= 4'd0;
            req_w    <= 1'b0;
            req_addr <= 32'h0;
            req_data <= 32'h0;
            req_type <= 3'b000;
            data_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_w    <= mem_w;
                req_addr <= Addr_in;
                req_data <= Data_in;
                req_type <= DMType;
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == DM_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (done && !req_w) data_q <= load_val;
        end
    end

    // Writes only on the DONE edge; reset parks the FSM so aborted stores never land.
    always_ff @(posedge clk) begin
        if (done && req_w && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: WAIT_CYCLES=1 main instance,
// WAIT_CYCLES=0 instance for back-to-back pulse spacing.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO, mem_w;
    logic [31:0] Addr_in, Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic        MIO_ready, acc_err;

    logic        cpu0, memw0;
    logic [31:0] addr0, din0, dout0;
    logic [2:0]  type0;
    logic        rdy0, err0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_load;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .Addr_in   (Addr_in),
        .Data_in   (Data_in),
        .DMType    (DMType),
        .Data_out  (Data_out),
        .MIO_ready (MIO_ready),
        .acc_err   (acc_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (cpu0),
        .mem_w     (memw0),
        .Addr_in   (addr0),
        .Data_in   (din0),
        .DMType    (type0),
        .Data_out  (dout0),
        .MIO_ready (rdy0),
        .acc_err   (err0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] t,
                          output logic [31:0] dout, output logic e,
                          output int lat);
        mem_w = w; Addr_in = a; Data_in = d; DMType = t; CPU_MIO = 1'b1;
        @(posedge clk); #1;
        // scramble inputs after acceptance; the DUT must use latched copies
        CPU_MIO = 1'b0; mem_w = ~w; Addr_in = 32'hFFFF_FFFC;
        Data_in = 32'h5A5A_5A5A; DMType = 3'b111;
        lat = 1;
        while (!MIO_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = Data_out;
        e    = acc_err;
        @(posedge clk); #1;
        chk("pulse", {30'h0, MIO_ready, acc_err}, 32'h0);
    endtask

    task automatic xact(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t, input logic [31:0] exp_d,
                        input logic exp_e);
        logic [31:0] got_d;
        logic        got_e;
        int          lat;
        do_req(w, a, d, t, got_d, got_e, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_err"}, {31'h0, got_e}, {31'h0, exp_e});
        if (!w) last_load = exp_d;
        chk({tag, "_data"}, got_d, last_load);
        chk({tag, "_hold"}, Data_out, last_load);
    endtask

    initial begin
        reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
        Addr_in = 32'h0; Data_in = 32'h0; DMType = 3'b000;
        cpu0 = 1'b0; memw0 = 1'b0; addr0 = 32'h0; din0 = 32'h0; type0 = 3'b000;
        last_load = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
        chk("rst_err",   {31'h0, acc_err},   32'h0);
        chk("rst_dout",  Data_out,           32'h0);
        @(negedge clk);
        reset = 1'b0;

        xact("st_w",    1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0,        0);
        xact("ld_w",    0, 32'h10, 32'h0,        3'b000, 32'hDEADBEEF, 0);
        xact("st_w0",   1, 32'h10, 32'h0,        3'b000, 32'h0,        0);
        xact("st_b",    1, 32'h13, 32'h80,       3'b100, 32'h0,        0);
        xact("ld_bs",   0, 32'h13, 32'h0,        3'b011, 32'hFFFFFF80, 0);
        xact("ld_bu",   0, 32'h13, 32'h0,        3'b100, 32'h00000080, 0);
        xact("ld_wb",   0, 32'h10, 32'h0,        3'b000, 32'h80000000, 0);
        xact("ld_hs",   0, 32'h12, 32'h0,        3'b001, 32'hFFFF8000, 0);
        xact("ld_hu",   0, 32'h12, 32'h0,        3'b010, 32'h00008000, 0);
        xact("ld_hmis", 0, 32'h11, 32'h0,        3'b001, 32'h0,        1);
        xact("st_w20",  1, 32'h20, 32'h11223344, 3'b000, 32'h0,        0);
        xact("st_wmis", 1, 32'h22, 32'h99999999, 3'b000, 32'h0,        1);
        xact("ld_w20",  0, 32'h20, 32'h0,        3'b000, 32'h11223344, 0);
        xact("ld_oor",  0, 32'h1000, 32'h0,      3'b000, 32'h0,        1);
        xact("ld_ill",  0, 32'h10, 32'h0,        3'b101, 32'h0,        1);
        xact("st_h",    1, 32'h22, 32'h0000BEEF, 3'b001, 32'h0,        0);
        xact("ld_w20h", 0, 32'h20, 32'h0,        3'b000, 32'hBEEF3344, 0);
        xact("st_w40",  1, 32'h40, 32'hA5A5A5A5, 3'b000, 32'h0,        0);
        xact("ld_w40",  0, 32'h40, 32'h0,        3'b000, 32'hA5A5A5A5, 0);

        // abort a store while it sits in WAIT
        mem_w = 1'b1; Addr_in = 32'h40; Data_in = 32'h12345678;
        DMType = 3'b000; CPU_MIO = 1'b1;
        @(posedge clk); #1;
        CPU_MIO = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_rdy", {31'h0, MIO_ready}, 32'h0);
        chk("abort_dout", Data_out, 32'h0);
        @(posedge clk); #1;
        chk("abort_rdy2", {31'h0, MIO_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        last_load = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_idle", {31'h0, MIO_ready}, 32'h0);
        end
        xact("ld_after", 0, 32'h40, 32'h0, 3'b000, 32'hA5A5A5A5, 0);

        // zero wait states, request held high continuously
        memw0 = 1'b1; addr0 = 32'h8; din0 = 32'hCAFEF00D; type0 = 3'b000;
        cpu0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            chk("b2b_rdy", {31'h0, rdy0}, 32'(i % 2));
        end
        cpu0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
